// File: rtl/dmem_responder.sv
// Word-organised data RAM behind the MIPS memory stage: each access completes LATENCY cycles after it is first seen.
// memstallM holds the M stage until DONE, and read data is registered at the edge that enters DONE.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic        storeselectM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        memstallM,
  output logic        misalignedM
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [31:0]     r_mem [DEPTH_WORDS];
  logic [31:0]     r_rdata;
  logic            r_mis;

  logic            w_req;
  logic            w_stall;
  logic            w_load;
  logic            w_commit;
  logic            w_set_mis;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_lane;

  // Address bits above the RAM index are ignored, so accesses wrap around the array.
  wire w_unused = ^addrM[31:AW+2];

  assign w_req  = memreadM | memwriteM;
  assign w_idx  = addrM[AW+1:2];
  assign w_lane = addrM[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_set_mis   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_stall   = 1'b1;
          w_cnt_nxt = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            w_state_nxt = S_DONE;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        // A dropped request abandons the access: no write and read data untouched.
        if (!w_req) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_state_nxt = S_DONE;
            w_load      = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_commit    = memwriteM;
        w_set_mis   = !storeselectM && (addrM[1:0] != 2'b00);
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_mis   <= 1'b0;
    end else begin
      if (w_load) begin
        r_rdata <= r_mem[w_idx];
      end
      if (w_set_mis) begin
        r_mis <= 1'b1;
      end
    end
  end

  // RAM contents survive reset; a store only lands on the edge leaving DONE.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (storeselectM) begin
        r_mem[w_idx][{w_lane, 3'b000} +: 8] <= writedataM[7:0];
      end else begin
        r_mem[w_idx] <= writedataM;
      end
    end
  end

  assign memstallM   = w_stall;
  assign readdataM   = r_rdata;
  assign misalignedM = r_mis;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder, checked every cycle against a transaction-level model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memreadM = 1'b0;
  logic        memwriteM = 1'b0;
  logic        storeselectM = 1'b0;
  logic [31:0] addrM = '0;
  logic [31:0] writedataM = '0;
  logic [31:0] readdataM;
  logic        memstallM;
  logic        misalignedM;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .memreadM     (memreadM),
    .memwriteM    (memwriteM),
    .storeselectM (storeselectM),
    .addrM        (addrM),
    .writedataM   (writedataM),
    .readdataM    (readdataM),
    .memstallM    (memstallM),
    .misalignedM  (misalignedM)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        exp_mis = 1'b0;

  logic [31:0] mdl_mem [DEPTH];
  logic        pend_vld = 1'b0;
  logic        pend_wr, pend_bs, pend_mis;
  int          pend_idx, pend_lane;
  logic [31:0] pend_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (memstallM !== exp_stall || readdataM !== exp_rdata || misalignedM !== exp_mis) begin
        n_err++;
        $display("FAIL cycle @%0t: stall=%b want %b rdata=%h want %h mis=%b want %b",
                 $time, memstallM, exp_stall, readdataM, exp_rdata, misalignedM, exp_mis);
      end
    end
  end

  // Start of a cycle: apply the effects of the access that completed in the previous cycle.
  task automatic cycle_start();
    logic [31:0] mask;
    @(posedge clk);
    #1;
    if (pend_vld) begin
      if (pend_wr) begin
        if (pend_bs) begin
          mask = 32'hFF << (8 * pend_lane);
          mdl_mem[pend_idx] = (mdl_mem[pend_idx] & ~mask) | ({24'b0, pend_dat[7:0]} << (8 * pend_lane));
        end else begin
          mdl_mem[pend_idx] = pend_dat;
        end
      end
      if (pend_mis) exp_mis = 1'b1;
      pend_vld = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle_start();
      memreadM  = 1'b0;
      memwriteM = 1'b0;
      exp_stall = 1'b0;
    end
  endtask

  // One access: stalled for LAT cycles, then a DONE cycle. abort_at>0 drops the request in that cycle.
  task automatic access(input logic rd, input logic wr, input logic bs, input logic [31:0] a,
                        input logic [31:0] d, input int abort_at,
                        output logic [31:0] rd_val, output int nstall);
    int idx;
    idx    = int'((a >> 2) % DEPTH);
    rd_val = '0;
    nstall = 0;
    for (int c = 0; c <= LAT; c++) begin
      cycle_start();
      if (c == 0) begin
        memreadM     = rd;
        memwriteM    = wr;
        storeselectM = bs;
        addrM        = a;
        writedataM   = d;
      end
      exp_stall = (c < LAT);
      if (c == LAT) exp_rdata = mdl_mem[idx];
      if (c > 0 && c == abort_at) begin
        memreadM  = 1'b0;
        memwriteM = 1'b0;
      end
      #3;
      if (memstallM) nstall++;
      if (c > 0 && c == abort_at) break;
      if (c == LAT) begin
        rd_val    = readdataM;
        pend_vld  = 1'b1;
        pend_wr   = wr;
        pend_bs   = bs;
        pend_idx  = idx;
        pend_lane = int'(a[1:0]);
        pend_dat  = d;
        pend_mis  = !bs && (a[1:0] != 2'b00);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          ns;
    logic        rd, wr, bs;
    logic [31:0] a;
    int          ab;

    #2;
    check("reset_stall", 32'(memstallM), 32'd0);
    check("reset_rdata", readdataM, 32'd0);
    check("reset_mis", 32'(misalignedM), 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      access(1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom, 0, v, ns);
    end

    access(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, v, ns);
    check("store_stall_cycles", 32'(ns), 32'd2);
    access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 0, v, ns);
    check("load_stall_cycles", 32'(ns), 32'd2);
    check("load_deadbeef", v, 32'hDEADBEEF);

    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h11223344, 0, v, ns);
    access(1'b0, 1'b1, 1'b1, 32'h22, 32'h5A5A5AAB, 0, v, ns);
    access(1'b0, 1'b1, 1'b1, 32'h23, 32'h777777CD, 0, v, ns);
    access(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 0, v, ns);
    check("byte_lanes", v, 32'hCDAB3344);

    access(1'b0, 1'b1, 1'b0, 32'h400, 32'h5, 0, v, ns);
    idle(1);
    access(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0, v, ns);
    check("wrap_load", v, 32'h5);

    access(1'b0, 1'b1, 1'b0, 32'h8, 32'h12345678, 0, v, ns);
    access(1'b0, 1'b1, 1'b0, 32'h8, 32'hFFFFFFFF, 1, v, ns);
    idle(1);
    check("abort_idle_stall", 32'(memstallM), 32'd0);
    access(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 0, v, ns);
    check("abort_old_value", v, 32'h12345678);

    check("mis_before", 32'(misalignedM), 32'd0);
    access(1'b1, 1'b0, 1'b0, 32'h13, 32'h0, 0, v, ns);
    check("misaligned_load", v, 32'hDEADBEEF);
    idle(1);
    check("mis_set", 32'(misalignedM), 32'd1);
    access(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 0, v, ns);
    access(1'b0, 1'b1, 1'b0, 32'h30, 32'h1, 0, v, ns);
    idle(1);
    check("mis_sticky", 32'(misalignedM), 32'd1);

    access(1'b1, 1'b1, 1'b0, 32'h30, 32'h2, 0, v, ns);
    check("rdwr_old_word", v, 32'h1);
    access(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 0, v, ns);
    check("rdwr_new_word", v, 32'h2);

    access(1'b0, 1'b1, 1'b0, 32'h40, 32'hA5A5A5A5, 0, v, ns);
    cycle_start();
    memreadM = 1'b0; memwriteM = 1'b1; storeselectM = 1'b0; addrM = 32'h40; writedataM = 32'h0;
    exp_stall = 1'b1;
    cycle_start();
    exp_stall = 1'b1;
    #2;
    reset     = 1'b0;
    memwriteM = 1'b0;
    exp_stall = 1'b0;
    exp_rdata = '0;
    exp_mis   = 1'b0;
    #1;
    check("rst_async_stall", 32'(memstallM), 32'd0);
    check("rst_async_rdata", readdataM, 32'd0);
    check("rst_async_mis", 32'(misalignedM), 32'd0);
    cycle_start();
    cycle_start();
    reset = 1'b1;
    access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 0, v, ns);
    check("rst_store_dropped", v, 32'hA5A5A5A5);

    for (int n = 0; n < 400; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      bs = wr ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = $urandom;
      if (!bs && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      ab = ($urandom_range(0, 7) == 0) ? 1 : 0;
      access(rd, wr, bs, a, $urandom, ab, v, ns);
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
